// File: rtl/riscv_i32_trap_csrs.sv
// Machine-mode trap and CSR state for the RV32I pipeline.
// Holds mstatus (MIE/MPIE), mtvec, mscratch, mepc, mcause, mtval and a
// free-running mcycle. Services execute-stage CSR accesses and produces the
// fetch redirect target for trap entry and mret.
module riscv_i32_trap_csrs #(
    parameter logic [31:0] RESET_MTVEC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        control_flow__trap__valid,
    input  logic        control_flow__trap__ret,
    input  logic [3:0]  control_flow__trap__cause,
    input  logic [31:0] control_flow__trap__pc,
    input  logic [31:0] control_flow__trap__value,
    input  logic        control_flow__async_cancel,
    input  logic [2:0]  csr_access__access,
    input  logic [11:0] csr_access__address,
    input  logic [31:0] csr_access__write_data,
    output logic [31:0] csr_read_data,
    output logic        csr_illegal,
    output logic [31:0] trap_redirect_pc,
    output logic        interrupt_enable,
    output logic        trap_taken
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;

    localparam logic [2:0] ACC_NONE  = 3'd0;
    localparam logic [2:0] ACC_READ  = 3'd1;
    localparam logic [2:0] ACC_WRITE = 3'd2;
    localparam logic [2:0] ACC_SET   = 3'd3;
    localparam logic [2:0] ACC_CLEAR = 3'd4;

    // True for every address that has a backing CSR.
    function automatic logic csr_is_mapped(input logic [11:0] addr);
        logic hit;
        case (addr)
            ADDR_MSTATUS, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
            ADDR_MCAUSE, ADDR_MTVAL, ADDR_MCYCLE: hit = 1'b1;
            default:                              hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Read-modify-write result for the write/set/clear operations.
    function automatic logic [31:0] csr_apply_op(input logic [2:0]  op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] operand);
        logic [31:0] result;
        case (op)
            ACC_WRITE: result = operand;
            ACC_SET:   result = old_val | operand;
            ACC_CLEAR: result = old_val & ~operand;
            default:   result = old_val;
        endcase
        return result;
    endfunction

    // Architectural state
    logic        mie_r;
    logic        mpie_r;
    logic [31:0] mtvec_r;
    logic [31:0] mscratch_r;
    logic [31:0] mepc_r;
    logic        mcause_int_r;
    logic [3:0]  mcause_code_r;
    logic [31:0] mtval_r;
    logic [31:0] mcycle_r;
    logic        trap_taken_r;

    // Decode and datapath
    logic        trap_entry_s;
    logic        trap_ret_s;
    logic        access_active_s;
    logic        access_modify_s;
    logic        addr_mapped_s;
    logic        csr_update_s;
    logic [31:0] mstatus_view_s;
    logic [31:0] mcause_view_s;
    logic [31:0] csr_old_s;
    logic [31:0] csr_new_s;
    logic [31:0] trap_base_s;
    logic [31:0] vector_offset_s;

    // Classify the trap bundle and the CSR access; a trap entry squashes the access.
    always_comb begin
        trap_entry_s    = control_flow__trap__valid;
        trap_ret_s      = control_flow__trap__ret & ~control_flow__trap__valid;
        access_active_s = 1'b0;
        access_modify_s = 1'b0;
        case (csr_access__access)
            ACC_READ: begin
                access_active_s = 1'b1;
                access_modify_s = 1'b0;
            end
            ACC_WRITE, ACC_SET, ACC_CLEAR: begin
                access_active_s = 1'b1;
                access_modify_s = 1'b1;
            end
            ACC_NONE: begin
                access_active_s = 1'b0;
                access_modify_s = 1'b0;
            end
            default: begin
                access_active_s = 1'b0;
                access_modify_s = 1'b0;
            end
        endcase
        addr_mapped_s = csr_is_mapped(csr_access__address);
        csr_update_s  = access_modify_s & addr_mapped_s & ~trap_entry_s;
    end

    // Assemble the software-visible views of the partially stored CSRs.
    always_comb begin
        mstatus_view_s = {19'd0, 2'b11, 3'd0, mpie_r, 3'd0, mie_r, 3'd0};
        mcause_view_s  = {mcause_int_r, 27'd0, mcause_code_r};
    end

    // Select the pre-update value of the addressed CSR and the value to write back.
    always_comb begin
        csr_old_s = 32'd0;
        case (csr_access__address)
            ADDR_MSTATUS:  csr_old_s = mstatus_view_s;
            ADDR_MTVEC:    csr_old_s = mtvec_r;
            ADDR_MSCRATCH: csr_old_s = mscratch_r;
            ADDR_MEPC:     csr_old_s = mepc_r;
            ADDR_MCAUSE:   csr_old_s = mcause_view_s;
            ADDR_MTVAL:    csr_old_s = mtval_r;
            ADDR_MCYCLE:   csr_old_s = mcycle_r;
            default:       csr_old_s = 32'd0;
        endcase
        csr_new_s = csr_apply_op(csr_access__access, csr_old_s, csr_access__write_data);
    end

    // Drive read data and the illegal-address flag; unmapped or idle accesses read 0.
    always_comb begin
        csr_read_data = 32'd0;
        csr_illegal   = 1'b0;
        if (access_active_s && addr_mapped_s) begin
            csr_read_data = csr_old_s;
            csr_illegal   = 1'b0;
        end else if (access_active_s) begin
            csr_read_data = 32'd0;
            csr_illegal   = 1'b1;
        end else begin
            csr_read_data = 32'd0;
            csr_illegal   = 1'b0;
        end
    end

    // Fetch redirect from pre-update mtvec/mepc; only interrupts use the vector table.
    always_comb begin
        trap_base_s      = {mtvec_r[31:2], 2'b00};
        vector_offset_s  = {26'd0, control_flow__trap__cause, 2'b00};
        trap_redirect_pc = 32'd0;
        if (trap_entry_s) begin
            if (mtvec_r[0] && control_flow__async_cancel) begin
                trap_redirect_pc = trap_base_s + vector_offset_s;
            end else begin
                trap_redirect_pc = trap_base_s;
            end
        end else if (trap_ret_s) begin
            trap_redirect_pc = mepc_r;
        end else begin
            trap_redirect_pc = 32'd0;
        end
    end

    // mstatus MIE/MPIE: trap stacks MIE, explicit CSR write beats mret, mret unstacks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mie_r  <= 1'b0;
            mpie_r <= 1'b0;
        end else if (trap_entry_s) begin
            mpie_r <= mie_r;
            mie_r  <= 1'b0;
        end else if (csr_update_s && (csr_access__address == ADDR_MSTATUS)) begin
            mie_r  <= csr_new_s[3];
            mpie_r <= csr_new_s[7];
        end else if (trap_ret_s) begin
            mie_r  <= mpie_r;
            mpie_r <= 1'b1;
        end else begin
            mie_r  <= mie_r;
            mpie_r <= mpie_r;
        end
    end

    // mtvec: software-written only; bit 1 is reserved and kept at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtvec_r <= RESET_MTVEC;
        end else if (csr_update_s && (csr_access__address == ADDR_MTVEC)) begin
            mtvec_r <= {csr_new_s[31:2], 1'b0, csr_new_s[0]};
        end else begin
            mtvec_r <= mtvec_r;
        end
    end

    // mscratch: plain software scratch register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mscratch_r <= 32'd0;
        end else if (csr_update_s && (csr_access__address == ADDR_MSCRATCH)) begin
            mscratch_r <= csr_new_s;
        end else begin
            mscratch_r <= mscratch_r;
        end
    end

    // mepc: captures the trapping PC, or a software write; always halfword aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mepc_r <= 32'd0;
        end else if (trap_entry_s) begin
            mepc_r <= {control_flow__trap__pc[31:1], 1'b0};
        end else if (csr_update_s && (csr_access__address == ADDR_MEPC)) begin
            mepc_r <= {csr_new_s[31:1], 1'b0};
        end else begin
            mepc_r <= mepc_r;
        end
    end

    // mcause: only the interrupt flag and 4-bit code are kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcause_int_r  <= 1'b0;
            mcause_code_r <= 4'd0;
        end else if (trap_entry_s) begin
            mcause_int_r  <= control_flow__async_cancel;
            mcause_code_r <= control_flow__trap__cause;
        end else if (csr_update_s && (csr_access__address == ADDR_MCAUSE)) begin
            mcause_int_r  <= csr_new_s[31];
            mcause_code_r <= csr_new_s[3:0];
        end else begin
            mcause_int_r  <= mcause_int_r;
            mcause_code_r <= mcause_code_r;
        end
    end

    // mtval: trap value on entry, otherwise software-writable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtval_r <= 32'd0;
        end else if (trap_entry_s) begin
            mtval_r <= control_flow__trap__value;
        end else if (csr_update_s && (csr_access__address == ADDR_MTVAL)) begin
            mtval_r <= csr_new_s;
        end else begin
            mtval_r <= mtval_r;
        end
    end

    // mcycle: free-running wrap-around counter; a CSR write replaces that cycle's increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcycle_r <= 32'd0;
        end else if (csr_update_s && (csr_access__address == ADDR_MCYCLE)) begin
            mcycle_r <= csr_new_s;
        end else begin
            mcycle_r <= mcycle_r + 32'd1;
        end
    end

    // trap_taken: one-cycle pulse following every trap entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_taken_r <= 1'b0;
        end else begin
            trap_taken_r <= trap_entry_s;
        end
    end

    // Registered status outputs
    always_comb begin
        interrupt_enable = mie_r;
        trap_taken       = trap_taken_r;
    end

endmodule

// File: tb/tb_riscv_i32_trap_csrs.sv
// Bench for riscv_i32_trap_csrs: directed vector table with hand-computed
// expectations, a reset-during-trap sequence, and randomized cycles checked
// against an architectural model of the machine-mode CSRs.
module tb_riscv_i32_trap_csrs;

    logic        clk;
    logic        reset;
    logic        t_valid;
    logic        t_ret;
    logic [3:0]  t_cause;
    logic [31:0] t_pc;
    logic [31:0] t_value;
    logic        t_async;
    logic [2:0]  c_access;
    logic [11:0] c_addr;
    logic [31:0] c_wd;
    logic [31:0] csr_read_data;
    logic        csr_illegal;
    logic [31:0] trap_redirect_pc;
    logic        interrupt_enable;
    logic        trap_taken;

    riscv_i32_trap_csrs #(.RESET_MTVEC(32'h0000_0100)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .control_flow__trap__valid  (t_valid),
        .control_flow__trap__ret    (t_ret),
        .control_flow__trap__cause  (t_cause),
        .control_flow__trap__pc     (t_pc),
        .control_flow__trap__value  (t_value),
        .control_flow__async_cancel (t_async),
        .csr_access__access         (c_access),
        .csr_access__address        (c_addr),
        .csr_access__write_data     (c_wd),
        .csr_read_data              (csr_read_data),
        .csr_illegal                (csr_illegal),
        .trap_redirect_pc           (trap_redirect_pc),
        .interrupt_enable           (interrupt_enable),
        .trap_taken                 (trap_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        valid;
        logic        ret;
        logic [3:0]  cause;
        logic [31:0] pc;
        logic [31:0] value;
        logic        async_c;
        logic [2:0]  access;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_ill;
        logic [31:0] exp_redir;
        logic        exp_ie;
        logic        exp_tt;
    } vec_t;

    function automatic vec_t mk(input logic valid, input logic ret, input logic [3:0] cause,
                                input logic [31:0] pc, input logic [31:0] value, input logic async_c,
                                input logic [2:0] access, input logic [11:0] addr, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input logic exp_ill, input logic [31:0] exp_redir,
                                input logic exp_ie, input logic exp_tt);
        vec_t v;
        v.valid = valid; v.ret = ret; v.cause = cause; v.pc = pc; v.value = value;
        v.async_c = async_c; v.access = access; v.addr = addr; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_ill = exp_ill; v.exp_redir = exp_redir;
        v.exp_ie = exp_ie; v.exp_tt = exp_tt;
        return v;
    endfunction

    // Architectural model: CSR contents as software sees them.
    logic        m_mie, m_mpie, m_tt;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle;

    task automatic model_reset();
        m_mie = 1'b0; m_mpie = 1'b0; m_tt = 1'b0;
        m_mtvec = 32'h0000_0100; m_mscratch = 32'd0; m_mepc = 32'd0;
        m_mcause = 32'd0; m_mtval = 32'd0; m_mcycle = 32'd0;
    endtask

    function automatic bit m_mapped(input logic [11:0] a);
        return (a == 12'h300) || (a == 12'h305) || (a == 12'h340) || (a == 12'h341) ||
               (a == 12'h342) || (a == 12'h343) || (a == 12'hB00);
    endfunction

    function automatic logic [31:0] m_csr(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00: return m_mcycle;
            default: return 32'd0;
        endcase
    endfunction

    // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
    task automatic step(input vec_t v, input bit has_exp, input string tag);
        logic [31:0] e_rd, e_redir, old, nv;
        logic        e_ill;
        bit          act, modify, mapped;
        logic        n_mie, n_mpie;
        logic [31:0] n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval, n_mcycle;
        t_valid = v.valid; t_ret = v.ret; t_cause = v.cause; t_pc = v.pc;
        t_value = v.value; t_async = v.async_c;
        c_access = v.access; c_addr = v.addr; c_wd = v.wd;
        #1;
        act    = (v.access >= 3'd1) && (v.access <= 3'd4);
        modify = (v.access >= 3'd2) && (v.access <= 3'd4);
        mapped = m_mapped(v.addr);
        old    = m_csr(v.addr);
        e_ill  = act && !mapped;
        e_rd   = (act && mapped) ? old : 32'd0;
        if (v.valid) begin
            e_redir = m_mtvec & 32'hFFFF_FFFC;
            if (m_mtvec[0] && v.async_c) e_redir = e_redir + 32'(v.cause) * 32'd4;
        end else if (v.ret) e_redir = m_mepc;
        else e_redir = 32'd0;
        check({tag, " read_data"}, csr_read_data, e_rd);
        check({tag, " illegal"}, {31'd0, csr_illegal}, {31'd0, e_ill});
        check({tag, " redirect"}, trap_redirect_pc, e_redir);
        if (has_exp) begin
            check({tag, " tbl read_data"}, csr_read_data, v.exp_rd);
            check({tag, " tbl illegal"}, {31'd0, csr_illegal}, {31'd0, v.exp_ill});
            check({tag, " tbl redirect"}, trap_redirect_pc, v.exp_redir);
        end
        n_mie = m_mie; n_mpie = m_mpie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
        n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval; n_mcycle = m_mcycle + 32'd1;
        if (v.valid) begin
            n_mepc   = v.pc & 32'hFFFF_FFFE;
            n_mcause = (v.async_c ? 32'h8000_0000 : 32'h0) | 32'(v.cause);
            n_mtval  = v.value;
            n_mpie   = m_mie;
            n_mie    = 1'b0;
        end else begin
            if (v.ret) begin
                n_mie  = m_mpie;
                n_mpie = 1'b1;
            end
            if (modify && mapped) begin
                if (v.access == 3'd2) nv = v.wd;
                else if (v.access == 3'd3) nv = old | v.wd;
                else nv = old & ~v.wd;
                case (v.addr)
                    12'h300: begin n_mie = nv[3]; n_mpie = nv[7]; end
                    12'h305: n_mtvec = nv & 32'hFFFF_FFFD;
                    12'h340: n_mscratch = nv;
                    12'h341: n_mepc = nv & 32'hFFFF_FFFE;
                    12'h342: n_mcause = nv & 32'h8000_000F;
                    12'h343: n_mtval = nv;
                    default: n_mcycle = nv;
                endcase
            end
        end
        @(posedge clk);
        m_mie = n_mie; m_mpie = n_mpie; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
        m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval; m_mcycle = n_mcycle;
        m_tt = v.valid;
        #1;
        check({tag, " interrupt_enable"}, {31'd0, interrupt_enable}, {31'd0, m_mie});
        check({tag, " trap_taken"}, {31'd0, trap_taken}, {31'd0, m_tt});
        if (has_exp) begin
            check({tag, " tbl interrupt_enable"}, {31'd0, interrupt_enable}, {31'd0, v.exp_ie});
            check({tag, " tbl trap_taken"}, {31'd0, trap_taken}, {31'd0, v.exp_tt});
        end
    endtask

    vec_t tbl[31];
    logic [11:0] addr_pool[8];

    initial begin
        vec_t rv;
        // valid ret cause pc value async | access addr wd | rd ill redir ie tt
        tbl[0]  = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'hB00,32'h0, 32'h0,0,32'h0,0,0);
        tbl[1]  = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'hB00,32'h0, 32'h1,0,32'h0,0,0);
        tbl[2]  = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'hB00,32'h0, 32'h2,0,32'h0,0,0);
        tbl[3]  = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h305,32'h0, 32'h100,0,32'h0,0,0);
        tbl[4]  = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h300,32'h0, 32'h1800,0,32'h0,0,0);
        tbl[5]  = mk(0,0,4'h0,32'h0,32'h0,0, 3'd2,12'h305,32'h8000_0003, 32'h100,0,32'h0,0,0);
        tbl[6]  = mk(0,0,4'h0,32'h0,32'h0,0, 3'd3,12'h300,32'h8, 32'h1800,0,32'h0,1,0);
        tbl[7]  = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h305,32'h0, 32'h8000_0001,0,32'h0,1,0);
        tbl[8]  = mk(1,0,4'h7,32'h41,32'h1234,1, 3'd1,12'h300,32'h0, 32'h1808,0,32'h8000_001C,0,1);
        tbl[9]  = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h341,32'h0, 32'h40,0,32'h0,0,0);
        tbl[10] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h342,32'h0, 32'h8000_0007,0,32'h0,0,0);
        tbl[11] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h300,32'h0, 32'h1880,0,32'h0,0,0);
        tbl[12] = mk(0,1,4'h0,32'h0,32'h0,0, 3'd1,12'h343,32'h0, 32'h1234,0,32'h40,1,0);
        tbl[13] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h300,32'h0, 32'h1888,0,32'h0,1,0);
        tbl[14] = mk(1,0,4'h2,32'h100,32'hDEAD_BEEF,0, 3'd2,12'h340,32'h55, 32'h0,0,32'h8000_0000,0,1);
        tbl[15] = mk(1,0,4'h3,32'h200,32'h0,1, 3'd1,12'h343,32'h0, 32'hDEAD_BEEF,0,32'h8000_000C,0,1);
        tbl[16] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h340,32'h0, 32'h0,0,32'h0,0,0);
        tbl[17] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd2,12'hB00,32'hFFFF_FFFF, 32'h11,0,32'h0,0,0);
        tbl[18] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'hB00,32'h0, 32'hFFFF_FFFF,0,32'h0,0,0);
        tbl[19] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'hB00,32'h0, 32'h0,0,32'h0,0,0);
        tbl[20] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h7C0,32'h0, 32'h0,1,32'h0,0,0);
        tbl[21] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd2,12'h7C0,32'hFFFF_FFFF, 32'h0,1,32'h0,0,0);
        tbl[22] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd0,12'h7C0,32'h0, 32'h0,0,32'h0,0,0);
        tbl[23] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd3,12'h300,32'h8, 32'h1800,0,32'h0,1,0);
        tbl[24] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd4,12'h300,32'h8, 32'h1808,0,32'h0,0,0);
        tbl[25] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h300,32'h0, 32'h1800,0,32'h0,0,0);
        tbl[26] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd5,12'h300,32'h0, 32'h0,0,32'h0,0,0);
        tbl[27] = mk(0,1,4'h0,32'h0,32'h0,0, 3'd2,12'h341,32'h77, 32'h200,0,32'h200,0,0);
        tbl[28] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h341,32'h0, 32'h76,0,32'h0,0,0);
        tbl[29] = mk(1,1,4'h1,32'h300,32'h0,1, 3'd1,12'h342,32'h0, 32'h8000_0003,0,32'h8000_0004,0,1);
        tbl[30] = mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h300,32'h0, 32'h1800,0,32'h0,0,0);

        addr_pool[0] = 12'h300; addr_pool[1] = 12'h305; addr_pool[2] = 12'h340;
        addr_pool[3] = 12'h341; addr_pool[4] = 12'h342; addr_pool[5] = 12'h343;
        addr_pool[6] = 12'hB00; addr_pool[7] = 12'h7C0;

        // Reset state
        reset = 1'b1;
        t_valid = 1'b0; t_ret = 1'b0; t_cause = 4'h0; t_pc = 32'h0; t_value = 32'h0;
        t_async = 1'b0; c_access = 3'd1; c_addr = 12'h305; c_wd = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset mtvec", csr_read_data, 32'h0000_0100);
        check("reset interrupt_enable", {31'd0, interrupt_enable}, 32'd0);
        check("reset trap_taken", {31'd0, trap_taken}, 32'd0);
        check("reset illegal", {31'd0, csr_illegal}, 32'd0);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 31; i++) step(tbl[i], 1'b1, $sformatf("row%0d", i));

        // Randomized cycles against the model
        for (int i = 0; i < 400; i++) begin
            rv = mk(0,0,4'h0,32'h0,32'h0,0, 3'd0,12'h0,32'h0, 32'h0,0,32'h0,0,0);
            rv.valid   = ($urandom_range(0, 5) == 0);
            rv.ret     = ($urandom_range(0, 5) == 0);
            rv.cause   = 4'($urandom);
            rv.pc      = $urandom;
            rv.value   = $urandom;
            rv.async_c = 1'($urandom);
            rv.access  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) rv.addr = 12'($urandom);
            else rv.addr = addr_pool[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0: rv.wd = 32'h0000_0088;
                1: rv.wd = 32'h0000_0008;
                default: rv.wd = $urandom;
            endcase
            step(rv, 1'b0, $sformatf("rand%0d", i));
        end

        // Reset asserted while a trap is being presented: trap is discarded
        t_valid = 1'b1; t_ret = 1'b0; t_cause = 4'h5; t_pc = 32'h504;
        t_value = 32'h99; t_async = 1'b1; c_access = 3'd0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset trap_taken", {31'd0, trap_taken}, 32'd0);
        check("midreset interrupt_enable", {31'd0, interrupt_enable}, 32'd0);
        t_valid = 1'b0; c_access = 3'd1; c_addr = 12'h341;
        #1;
        check("midreset mepc", csr_read_data, 32'h0);
        c_addr = 12'h305;
        #1;
        check("midreset mtvec", csr_read_data, 32'h0000_0100);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h342,32'h0, 32'h0,0,32'h0,0,0), 1'b1, "post0");
        step(mk(0,0,4'h0,32'h0,32'h0,0, 3'd1,12'h343,32'h0, 32'h0,0,32'h0,0,0), 1'b1, "post1");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/riscv_i32_trap_csrs.md
# riscv_i32_trap_csrs

Machine-mode trap and CSR state block for the RV32I pipeline. It sits directly downstream of the control-flow stage and consumes that stage's trap bundle: trap valid, return, cause, PC, value and async-cancel. It holds mstatus, mtvec, mscratch, mepc, mcause, mtval and a free-running mcycle, and services execute-stage CSR accesses. It also supplies the fetch redirect PC for trap entry and for mret.

## Interface
- Parameters:
- RESET_MTVEC, 32'h0, reset value of mtvec (base and mode).
- Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- control_flow__trap__valid  input  1  trap entry this cycle.
- control_flow__trap__ret  input  1  mret this cycle.
- control_flow__trap__cause  input  4  exception or interrupt cause.
- control_flow__trap__pc  input  32  PC of the trapping instruction.
- control_flow__trap__value  input  32  trap value for mtval.
- control_flow__async_cancel  input  1  trap is an interrupt; sets mcause[31].
- csr_access__access  input  3  0 none, 1 read, 2 write, 3 set, 4 clear; 5-7 treated as none.
- csr_access__address  input  12  CSR address.
- csr_access__write_data  input  32  write, set or clear operand.
- csr_read_data  output  32  pre-update value of the addressed CSR (combinational).
- csr_illegal  output  1  access nonzero and address unmapped (combinational).
- trap_redirect_pc  output  32  fetch target for trap or mret (combinational).
- interrupt_enable  output  1  mstatus.MIE (registered).
- trap_taken  output  1  registered one-cycle pulse after a trap entry.

## Operation
- CSR map:
  - mstatus is 0x300. Only MIE (bit 3) and MPIE (bit 7) are stored; MPP [12:11] reads 2'b11; all other bits read 0.
  - mtvec is 0x305. Bit 1 is forced to 0 on write; bit 0 is the mode: 0 direct, 1 vectored.
  - mscratch is 0x340.
  - mepc is 0x341. Bit 0 is forced to 0 on write.
  - mcause is 0x342. Bits [30:4] are not stored and always read 0.
  - mtval is 0x343.
  - mcycle is 0xB00 (32 bit).
- CSR write semantics:
  - write: new = wd.
  - set: new = old | wd.
  - clear: new = old & ~wd.
  - read: no change.
  - Unmapped address: csr_illegal=1, read data 0, no state change.
- Trap entry (trap__valid=1, trap__ret=0):
  - mepc <= {pc[31:1],1'b0}.
  - mcause <= {async_cancel, 27'b0, cause}.
  - mtval <= value.
  - MPIE <= MIE; MIE <= 0.
  - trap_taken <= 1 on the next edge.
- mret (trap__ret=1, trap__valid=0): MIE <= MPIE; MPIE <= 1.
- trap__valid and trap__ret both 1: treat as trap entry; ret is ignored.
- trap_redirect_pc selection:
  - Trap with vectored mode and async_cancel=1: {mtvec[31:2],2'b00} + (cause<<2).
  - Any other trap: {mtvec[31:2],2'b00}.
  - mret: mepc.
  - Neither: 32'h0.
- CSR access in the same cycle as trap__valid: suppressed entirely (the instruction did not commit); read data is still driven. CSR access with trap__ret proceeds.
- mcycle increments every cycle and wraps 0xFFFFFFFF -> 0. A CSR write, set or clear to mcycle in a cycle replaces that cycle's increment.
- Redirect uses pre-update state: a CSR write to mtvec or mepc in the same cycle does not affect that cycle's redirect.

## Timing
- Reset (async, immediate):
  - All CSRs are 0, except mtvec = RESET_MTVEC.
  - interrupt_enable=0, trap_taken=0.
  - Combinational outputs follow from the reset state.
- csr_read_data, csr_illegal and trap_redirect_pc are zero-latency combinational from inputs and current state.
- Every state update is visible one cycle after the edge that samples it; a read issued in the cycle after a write returns the new value.
- trap_taken is high for exactly one cycle per trap entry; back-to-back traps give a pulse on each cycle.
- Reset asserted mid-trap: the trap update is discarded and trap_taken stays 0.

## Test plan
- Reset with RESET_MTVEC=32'h0000_0100; read 0x305 -> 32'h100. Read 0x300 -> 32'h1800. mcycle counts 0,1,2 on successive reads.
- Write mtvec=32'h8000_0001 and set mstatus bit 3. Then trap with cause 4'h7, async_cancel=1, pc 32'h40:
  - redirect = 32'h8000_001C.
  - Next cycle: mepc=32'h40, mcause=32'h8000_0007, MIE=0, MPIE=1, trap_taken=1 for one cycle.
- mret after that trap: redirect = 32'h40; next cycle MIE=1, MPIE=1.
- Trap (cause 2, value 32'hDEAD_BEEF) in the same cycle as a write of 32'h55 to mscratch: mscratch is unchanged and mtval=32'hDEAD_BEEF.
- Write mcycle=32'hFFFF_FFFF, then read on the next two cycles -> 32'hFFFF_FFFF, then 32'h0.
- Access to 0x7C0 -> csr_illegal=1, read data 0, no CSR changes. Clear on 0x300 with 32'h8 -> MIE=0.
